// File: rtl/r4_fft_sched_if.sv
// Control/address bundle between the radix-4 FFT sequencer and its datapath.
// The stage_done strobe exists only when R4_SCHED_STAGE_IRQ_EN is defined.
interface r4_fft_sched_if #(
  parameter int AW = 6
);
  logic          ena;
  logic          start;
  logic          busy;
  logic          done;
  logic [1:0]    stage;
  logic          rd_vld;
  logic [AW-1:0] rd_a, rd_b, rd_c, rd_d;
  logic [AW-1:0] tw_idx;
  logic          bfly_en;
  logic          wr_vld;
  logic [AW-1:0] wr_a, wr_b, wr_c, wr_d;
`ifdef R4_SCHED_STAGE_IRQ_EN
  logic          stage_done;

  modport slave (
    input  ena, start,
    output busy, done, stage, rd_vld, rd_a, rd_b, rd_c, rd_d, tw_idx,
           bfly_en, wr_vld, wr_a, wr_b, wr_c, wr_d, stage_done
  );
  modport master (
    output ena, start,
    input  busy, done, stage, rd_vld, rd_a, rd_b, rd_c, rd_d, tw_idx,
           bfly_en, wr_vld, wr_a, wr_b, wr_c, wr_d, stage_done
  );
`else
  modport slave (
    input  ena, start,
    output busy, done, stage, rd_vld, rd_a, rd_b, rd_c, rd_d, tw_idx,
           bfly_en, wr_vld, wr_a, wr_b, wr_c, wr_d
  );
  modport master (
    output ena, start,
    input  busy, done, stage, rd_vld, rd_a, rd_b, rd_c, rd_d, tw_idx,
           bfly_en, wr_vld, wr_a, wr_b, wr_c, wr_d
  );
`endif
endinterface

// File: rtl/r4_fft_sched.sv
// Stage/butterfly sequencer for an in-place radix-4 DIF FFT: read addresses,
// twiddle exponent and delayed write-back. Optional macro: R4_SCHED_STAGE_IRQ_EN.
module r4_fft_sched #(
  parameter int LOG4N  = 3,
  parameter int AW     = 2*LOG4N,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  r4_fft_sched_if.slave bus
);
  localparam int            N     = 1 << AW;
  localparam int            DL    = RD_LAT + BF_LAT;
  localparam logic [AW-1:0] JLAST = AW'(N/4 - 1);
  localparam logic [1:0]    SLAST = 2'(LOG4N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed { logic [AW-1:0] a, b, c, d; } quad_t;
  typedef struct packed { quad_t q; logic [AW-1:0] tw; } issue_t;

  // Stage s splits j into group g (high bits) and offset k (low 2(LOG4N-1-s) bits).
  function automatic issue_t addr_gen(input logic [1:0] s, input logic [AW-1:0] j);
    issue_t        r;
    logic [AW-1:0] l, k, g, base;
    int            sh;
    sh    = AW - 2*(int'(s) + 1);
    l     = AW'(1) << sh;
    k     = j & (l - AW'(1));
    g     = j >> sh;
    base  = (g << (sh + 2)) + k;
    r.q.a = base;
    r.q.b = base + l;
    r.q.c = base + (l << 1);
    r.q.d = base + (l << 1) + l;
    r.tw  = k << (2*int'(s));
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    stage_q, stage_d;
  logic [AW-1:0] j_q, j_d;
  quad_t         rd_q, rd_d;
  logic [AW-1:0] tw_q, tw_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_last_q, rd_last_d;
  logic [DL-1:0] dl_vld_q;
  logic [DL-1:0] dl_last_q;
  quad_t         dl_addr_q [DL];

  logic [1:0]    gen_s;
  logic [AW-1:0] gen_j;
  logic          load;
  issue_t        issue_nxt;
  logic          busy_w;

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    j_d       = j_q;
    rd_vld_d  = rd_vld_q;
    rd_last_d = rd_last_q;
    gen_s     = stage_q;
    gen_j     = j_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          stage_d   = '0;
          j_d       = '0;
          gen_s     = '0;
          gen_j     = '0;
          load      = 1'b1;
          rd_vld_d  = 1'b1;
          rd_last_d = (JLAST == '0);
        end
      end
      RUN: begin
        if (j_q == JLAST) begin
          state_d   = DRAIN;
          rd_vld_d  = 1'b0;
          rd_last_d = 1'b0;
        end else begin
          j_d       = j_q + AW'(1);
          gen_j     = j_q + AW'(1);
          load      = 1'b1;
          rd_vld_d  = 1'b1;
          rd_last_d = ((j_q + AW'(1)) == JLAST);
        end
      end
      DRAIN: begin
        // The last butterfly of the stage is on the write port this cycle.
        if (dl_last_q[DL-1]) begin
          if (stage_q == SLAST) begin
            state_d = DONE;
          end else begin
            state_d   = RUN;
            stage_d   = stage_q + 2'd1;
            j_d       = '0;
            gen_s     = stage_q + 2'd1;
            gen_j     = '0;
            load      = 1'b1;
            rd_vld_d  = 1'b1;
            rd_last_d = (JLAST == '0);
          end
        end
      end
      DONE: state_d = IDLE;
    endcase
    issue_nxt = addr_gen(gen_s, gen_j);
    rd_d      = load ? issue_nxt.q  : rd_q;
    tw_d      = load ? issue_nxt.tw : tw_q;
  end

`ifdef R4_SCHED_STAGE_IRQ_EN
  logic stage_done_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      j_q       <= '0;
      rd_q      <= '0;
      tw_q      <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      dl_vld_q  <= '0;
      dl_last_q <= '0;
      for (int i = 0; i < DL; i++) dl_addr_q[i] <= '0;
`ifdef R4_SCHED_STAGE_IRQ_EN
      stage_done_q <= 1'b0;
`endif
    end else if (bus.ena) begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      j_q          <= j_d;
      rd_q         <= rd_d;
      tw_q         <= tw_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      dl_vld_q[0]  <= rd_vld_q;
      dl_last_q[0] <= rd_last_q;
      dl_addr_q[0] <= rd_q;
      for (int i = 1; i < DL; i++) begin
        dl_vld_q[i]  <= dl_vld_q[i-1];
        dl_last_q[i] <= dl_last_q[i-1];
        dl_addr_q[i] <= dl_addr_q[i-1];
      end
`ifdef R4_SCHED_STAGE_IRQ_EN
      stage_done_q <= dl_last_q[DL-1];
`endif
    end
  end

  assign busy_w      = (state_q == RUN) || (state_q == DRAIN);
  assign bus.busy    = busy_w;
  assign bus.done    = (state_q == DONE);
  assign bus.stage   = stage_q;
  // Strobes are gated by ena so a stalled cycle never looks like a transfer.
  assign bus.rd_vld  = rd_vld_q & bus.ena;
  assign bus.rd_a    = rd_q.a;
  assign bus.rd_b    = rd_q.b;
  assign bus.rd_c    = rd_q.c;
  assign bus.rd_d    = rd_q.d;
  assign bus.tw_idx  = tw_q;
  assign bus.bfly_en = bus.ena & busy_w;
  assign bus.wr_vld  = dl_vld_q[DL-1] & bus.ena;
  assign bus.wr_a    = dl_addr_q[DL-1].a;
  assign bus.wr_b    = dl_addr_q[DL-1].b;
  assign bus.wr_c    = dl_addr_q[DL-1].c;
  assign bus.wr_d    = dl_addr_q[DL-1].d;
`ifdef R4_SCHED_STAGE_IRQ_EN
  assign bus.stage_done = stage_done_q;
`endif
endmodule

// File: tb/tb_r4_fft_sched.sv
// Directed bench for r4_fft_sched (64-point default); stage_done checks are
// compiled in when R4_SCHED_STAGE_IRQ_EN is defined.
module tb_r4_fft_sched;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  r4_fft_sched_if #(.AW(AW)) bus ();
  r4_fft_sched #(.LOG4N(3), .AW(AW), .RD_LAT(1), .BF_LAT(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    int stall_at; int stall_len; int restart_at; int exp_done; int exp_sd0;
  } scen_t;
  typedef struct packed {
    int scen; int is_wr; int idx; int cyc; int st; int a; int b; int c; int d; int tw;
  } ev_t;

  scen_t scen [5];
  ev_t   ev   [20];

  int tests = 0;
  int fails = 0;
  int rel;
  int nrd, nwr, ndone, stall_viol, done_cyc, busy_at_done, busy_before, busy_prev;
  int rd_cyc [64], rd_st [64], rd_al [64], rd_bl [64], rd_cl [64], rd_dl [64], rd_tl [64];
  int wr_cyc [64], wr_al [64], wr_bl [64], wr_cl [64], wr_dl [64];
  int ea [48], eb [48], ec [48], ed [48], et [48], es [48];
  int m_idx, m_l, bad;
`ifdef R4_SCHED_STAGE_IRQ_EN
  int nsd;
  int sd_cyc [8];
`endif

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    nrd = 0; nwr = 0; ndone = 0; stall_viol = 0; done_cyc = -1;
    busy_at_done = -1; busy_before = -1; busy_prev = 0;
`ifdef R4_SCHED_STAGE_IRQ_EN
    nsd = 0;
`endif
  endtask

  task automatic sample();
    if (bus.rd_vld) begin
      if (nrd < 64) begin
        rd_cyc[nrd] = rel; rd_st[nrd] = int'(bus.stage);
        rd_al[nrd] = int'(bus.rd_a); rd_bl[nrd] = int'(bus.rd_b);
        rd_cl[nrd] = int'(bus.rd_c); rd_dl[nrd] = int'(bus.rd_d);
        rd_tl[nrd] = int'(bus.tw_idx);
      end
      nrd++;
    end
    if (bus.wr_vld) begin
      if (nwr < 64) begin
        wr_cyc[nwr] = rel;
        wr_al[nwr] = int'(bus.wr_a); wr_bl[nwr] = int'(bus.wr_b);
        wr_cl[nwr] = int'(bus.wr_c); wr_dl[nwr] = int'(bus.wr_d);
      end
      nwr++;
    end
    if (!bus.ena && (bus.rd_vld || bus.wr_vld || bus.bfly_en)) stall_viol++;
    if (bus.done) begin
      if (ndone == 0) begin
        done_cyc = rel; busy_at_done = int'(bus.busy); busy_before = busy_prev;
      end
      ndone++;
    end
    busy_prev = int'(bus.busy);
`ifdef R4_SCHED_STAGE_IRQ_EN
    if (bus.stage_done) begin
      if (nsd < 8) sd_cyc[nsd] = rel;
      nsd++;
    end
`endif
  endtask

  task automatic run_xfer(input int stall_at, input int stall_len, input int restart_at);
    clear_logs();
    rel = 0;
    bus.start = 1'b1;
    bus.ena   = 1'b1;
    while (ndone == 0 && rel < 200) begin
      @(posedge clk); #1;
      rel++;
      bus.start = (rel == restart_at);
      bus.ena   = !(rel >= stall_at && rel < stall_at + stall_len);
      #1;
      sample();
    end
    bus.start = 1'b0;
    bus.ena   = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      rel++;
      sample();
    end
  endtask

  task automatic check_seq(input string tag);
    bad = 0;
    for (int i = 0; i < 48; i++)
      if (rd_al[i] != ea[i] || rd_bl[i] != eb[i] || rd_cl[i] != ec[i] ||
          rd_dl[i] != ed[i] || rd_tl[i] != et[i]) bad++;
    check({tag, ".rd_seq_errs"}, bad, 0);
    bad = 0;
    for (int i = 0; i < 48; i++) if (rd_st[i] != es[i]) bad++;
    check({tag, ".stage_errs"}, bad, 0);
    bad = 0;
    for (int i = 0; i < 48; i++)
      if (wr_al[i] != ea[i] || wr_bl[i] != eb[i] || wr_cl[i] != ec[i] || wr_dl[i] != ed[i]) bad++;
    check({tag, ".wr_seq_errs"}, bad, 0);
  endtask

  initial begin
    //                 stall_at stall_len restart done sd0
    scen[0] = '{-100, 0,  -1, 61, 21};
    scen[1] = '{   8, 7,  -1, 68, 28};
    scen[2] = '{-100, 0,  10, 61, 21};
    scen[3] = '{  18, 3,  -1, 64, 24};
    scen[4] = '{  20, 2,  -1, 63, 23};

    //          scen wr idx cyc st  a   b   c   d  tw
    ev[0]  = '{0, 0,  0,  1, 0,  0, 16, 32, 48,  0};
    ev[1]  = '{0, 0,  1,  2, 0,  1, 17, 33, 49,  1};
    ev[2]  = '{0, 0, 15, 16, 0, 15, 31, 47, 63, 15};
    ev[3]  = '{0, 0, 16, 21, 1,  0,  4,  8, 12,  0};
    ev[4]  = '{0, 0, 21, 26, 1, 17, 21, 25, 29,  4};
    ev[5]  = '{0, 0, 22, 27, 1, 18, 22, 26, 30,  8};
    ev[6]  = '{0, 0, 31, 36, 1, 51, 55, 59, 63, 12};
    ev[7]  = '{0, 0, 32, 41, 2,  0,  1,  2,  3,  0};
    ev[8]  = '{0, 0, 39, 48, 2, 28, 29, 30, 31,  0};
    ev[9]  = '{0, 0, 47, 56, 2, 60, 61, 62, 63,  0};
    ev[10] = '{0, 1,  0,  5, 0,  0, 16, 32, 48,  0};
    ev[11] = '{0, 1, 15, 20, 0, 15, 31, 47, 63,  0};
    ev[12] = '{0, 1, 16, 25, 0,  0,  4,  8, 12,  0};
    ev[13] = '{0, 1, 47, 60, 0, 60, 61, 62, 63,  0};
    ev[14] = '{1, 0,  6,  7, 0,  6, 22, 38, 54,  6};
    ev[15] = '{1, 0,  7, 15, 0,  7, 23, 39, 55,  7};
    ev[16] = '{1, 1,  2,  7, 0,  2, 18, 34, 50,  0};
    ev[17] = '{1, 1,  3, 15, 0,  3, 19, 35, 51,  0};
    ev[18] = '{4, 1, 15, 22, 0, 15, 31, 47, 63,  0};
    ev[19] = '{3, 1, 15, 23, 0, 15, 31, 47, 63,  0};

    m_idx = 0;
    for (int s = 0; s < 3; s++) begin
      m_l = 64 / (4**(s+1));
      for (int g = 0; g < 64 / (4*m_l); g++)
        for (int k = 0; k < m_l; k++) begin
          ea[m_idx] = g*4*m_l + k;
          eb[m_idx] = ea[m_idx] + m_l;
          ec[m_idx] = ea[m_idx] + 2*m_l;
          ed[m_idx] = ea[m_idx] + 3*m_l;
          et[m_idx] = k * (4**s);
          es[m_idx] = s;
          m_idx++;
        end
    end

    rst = 1'b1; bus.ena = 1'b1; bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy",    int'(bus.busy),    0);
    check("rst.done",    int'(bus.done),    0);
    check("rst.stage",   int'(bus.stage),   0);
    check("rst.rd_vld",  int'(bus.rd_vld),  0);
    check("rst.wr_vld",  int'(bus.wr_vld),  0);
    check("rst.bfly_en", int'(bus.bfly_en), 0);
    check("rst.rd_a",    int'(bus.rd_a),    0);
    check("rst.rd_d",    int'(bus.rd_d),    0);
    check("rst.tw_idx",  int'(bus.tw_idx),  0);
    check("rst.wr_a",    int'(bus.wr_a),    0);
    check("rst.wr_d",    int'(bus.wr_d),    0);
    rst = 1'b0; bus.start = 1'b0;
    @(posedge clk); #2;

    for (int si = 0; si < 5; si++) begin
      run_xfer(scen[si].stall_at, scen[si].stall_len, scen[si].restart_at);
      check($sformatf("s%0d.done_cyc", si), done_cyc, scen[si].exp_done);
      check($sformatf("s%0d.ndone", si), ndone, 1);
      check($sformatf("s%0d.nrd", si), nrd, 48);
      check($sformatf("s%0d.nwr", si), nwr, 48);
      check($sformatf("s%0d.stall_strobes", si), stall_viol, 0);
      check($sformatf("s%0d.busy_at_done", si), busy_at_done, 0);
      check($sformatf("s%0d.busy_before_done", si), busy_before, 1);
      check_seq($sformatf("s%0d", si));
      for (int e = 0; e < 20; e++) begin
        if (ev[e].scen == si) begin
          if (ev[e].is_wr != 0) begin
            check($sformatf("ev%0d.wr_cyc", e), wr_cyc[ev[e].idx], ev[e].cyc);
            check($sformatf("ev%0d.wr_a", e), wr_al[ev[e].idx], ev[e].a);
            check($sformatf("ev%0d.wr_d", e), wr_dl[ev[e].idx], ev[e].d);
          end else begin
            check($sformatf("ev%0d.rd_cyc", e), rd_cyc[ev[e].idx], ev[e].cyc);
            check($sformatf("ev%0d.stage", e), rd_st[ev[e].idx], ev[e].st);
            check($sformatf("ev%0d.rd_a", e), rd_al[ev[e].idx], ev[e].a);
            check($sformatf("ev%0d.rd_b", e), rd_bl[ev[e].idx], ev[e].b);
            check($sformatf("ev%0d.rd_c", e), rd_cl[ev[e].idx], ev[e].c);
            check($sformatf("ev%0d.rd_d", e), rd_dl[ev[e].idx], ev[e].d);
            check($sformatf("ev%0d.tw", e), rd_tl[ev[e].idx], ev[e].tw);
          end
        end
      end
`ifdef R4_SCHED_STAGE_IRQ_EN
      check($sformatf("s%0d.nsd", si), nsd, 3);
      for (int k = 0; k < 3; k++)
        check($sformatf("s%0d.sd_cyc%0d", si, k), sd_cyc[k], scen[si].exp_sd0 + 20*k);
`endif
      repeat (2) @(posedge clk);
      #2;
    end

    // Reset at cycle 30 with start held high abandons the transform.
    clear_logs();
    rel = 0;
    bus.start = 1'b1; bus.ena = 1'b1;
    while (rel < 30) begin
      @(posedge clk); #1;
      rel++;
      bus.start = 1'b0;
      #1;
      sample();
    end
    check("prerst.nrd", nrd, 26);
    check("prerst.nwr", nwr, 22);
    rst = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    #1;
    check("midrst.busy",    int'(bus.busy),    0);
    check("midrst.stage",   int'(bus.stage),   0);
    check("midrst.rd_vld",  int'(bus.rd_vld),  0);
    check("midrst.wr_vld",  int'(bus.wr_vld),  0);
    check("midrst.bfly_en", int'(bus.bfly_en), 0);
    check("midrst.rd_a",    int'(bus.rd_a),    0);
    check("midrst.tw_idx",  int'(bus.tw_idx),  0);
    check("midrst.wr_b",    int'(bus.wr_b),    0);
`ifdef R4_SCHED_STAGE_IRQ_EN
    check("midrst.stage_done", int'(bus.stage_done), 0);
`endif
    repeat (10) begin
      @(posedge clk); #2;
      rel++;
      sample();
    end
    check("postrst.nrd", nrd, 26);
    check("postrst.nwr", nwr, 22);
    check("postrst.ndone", ndone, 0);

    run_xfer(-100, 0, -1);
    check("rerun.done_cyc", done_cyc, 61);
    check("rerun.nrd", nrd, 48);
    check("rerun.nwr", nwr, 48);
    check("rerun.first_rd_cyc", rd_cyc[0], 1);
    check("rerun.first_wr_cyc", wr_cyc[0], 5);
    check_seq("rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
